lfsr_seq_ctrl: RTL

Sequencer for the 8-bit Galois LFSR generator and its lock checker. On a start command it loads a seed with the generator's synchronous soft reset, then paces the generator's valid strobe at a programmable rate. It waits for the checker to report lock, runs a programmed number of words, and reports pass or fail. It sits between the register/control interface and the lfsr_galois instance.

---
 rtl/lfsr_seq_ctrl_pkg.sv | 23 ++
 rtl/lfsr_seq_ctrl_if.sv | 34 +++
 rtl/lfsr_seq_ctrl_rate_div.sv | 41 ++++
 rtl/lfsr_seq_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/lfsr_seq_ctrl_pkg.sv
// Shared constants for the LFSR sequencer: FSM state codes, default widths,
// the fixed hardware seed shared by generator and checker, and small helpers.
package lfsr_seq_ctrl_pkg;

  localparam int DATA_W_DEF       = 8;
  localparam int CNT_W_DEF        = 16;
  localparam int DIV_W_DEF        = 4;
  localparam int LOCK_TIMEOUT_DEF = 64;

  localparam logic [7:0] HW_SEED = 8'h01;

  localparam int ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
  localparam logic [ST_W-1:0] ST_LOAD = 3'd1;
  localparam logic [ST_W-1:0] ST_ACQ  = 3'd2;
  localparam logic [ST_W-1:0] ST_RUN  = 3'd3;
  localparam logic [ST_W-1:0] ST_DONE = 3'd4;

  function automatic logic st_is_busy(input logic [ST_W-1:0] st);
    return (st == ST_LOAD) || (st == ST_ACQ) || (st == ST_RUN);
  endfunction

endpackage

// File: rtl/lfsr_seq_ctrl_if.sv
// Control/status bundle between the register block (master) and the
// sequencer (slave); also carries the checker lock flag.
interface lfsr_seq_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16,
  parameter int DIV_W  = 4
);
  logic              i_start;
  logic              i_abort;
  logic [DATA_W-1:0] i_seed;
  logic [CNT_W-1:0]  i_num_words;
  logic [DIV_W-1:0]  i_div;
  logic              i_lock;
  logic              o_soft_reset;
  logic [DATA_W-1:0] o_seed;
  logic              o_valid;
  logic              o_busy;
  logic              o_done;
  logic              o_pass;
  logic [CNT_W-1:0]  o_word_cnt;
  logic [CNT_W-1:0]  o_loss_cnt;

  modport slave (
    input  i_start, i_abort, i_seed, i_num_words, i_div, i_lock,
    output o_soft_reset, o_seed, o_valid, o_busy, o_done, o_pass,
           o_word_cnt, o_loss_cnt
  );

  modport master (
    output i_start, i_abort, i_seed, i_num_words, i_div, i_lock,
    input  o_soft_reset, o_seed, o_valid, o_busy, o_done, o_pass,
           o_word_cnt, o_loss_cnt
  );
endinterface

// File: rtl/lfsr_seq_ctrl_rate_div.sv
// Valid-rate divider: registered tick every (i_div+1) enabled cycles.
// i_load/i_en describe the *next* cycle so the tick itself is a flop output.
module lfsr_seq_ctrl_rate_div #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_cnt_next;
  logic             r_tick;

  // r_cnt is the divider value of the current cycle; it wraps on a tick.
  always_comb begin
    w_cnt_next = r_cnt + DIV_W'(1);
    if (i_load || r_tick) begin
      w_cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_tick <= (w_cnt_next == i_div);
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Sequencer for the Galois LFSR generator/checker pair: seed load, paced
// valid strobes, lock acquisition with timeout, word run and pass/fail.
module lfsr_seq_ctrl
  import lfsr_seq_ctrl_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
  parameter int DIV_W        = DIV_W_DEF
) (
  input  logic                clk,
  input  logic                i_rst_n,
  lfsr_seq_ctrl_if.slave      io_bus
);

  localparam int ACQ_W = $clog2(LOCK_TIMEOUT + 1);

  logic [ST_W-1:0]   r_state;
  logic [DATA_W-1:0] r_seed;
  logic [CNT_W-1:0]  r_num_words;
  logic [DIV_W-1:0]  r_div;
  logic [CNT_W-1:0]  r_word_cnt;
  logic [CNT_W-1:0]  r_loss_cnt;
  logic [ACQ_W-1:0]  r_acq_cnt;
  logic              r_lock_prev;
  logic              r_pass;
  logic              r_done;
  logic              r_busy;
  logic              r_soft_reset;

  logic [ST_W-1:0]   w_state_next;
  logic              w_accept;
  logic              w_valid;
  logic [CNT_W-1:0]  w_word_inc;
  logic [CNT_W-1:0]  w_loss_next;
  logic [ACQ_W-1:0]  w_acq_inc;
  logic              w_pass_run;
  logic              w_div_load;
  logic              w_div_en;

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_word_inc   = r_word_cnt + CNT_W'(1);
    w_acq_inc    = r_acq_cnt + ACQ_W'(1);
    w_loss_next  = r_loss_cnt;
    // Lock loss is a falling edge of the checker flag seen while running.
    if ((r_state == ST_RUN) && r_lock_prev && !io_bus.i_lock && (r_loss_cnt != '1)) begin
      w_loss_next = r_loss_cnt + CNT_W'(1);
    end
    w_pass_run = (w_loss_next == '0) && io_bus.i_lock;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (io_bus.i_start) begin
          w_state_next = ST_LOAD;
          w_accept     = 1'b1;
        end
      end
      ST_LOAD: w_state_next = ST_ACQ;
      ST_ACQ: begin
        if (io_bus.i_lock) begin
          w_state_next = ST_RUN;
        end else if (w_valid && (w_acq_inc == ACQ_W'(LOCK_TIMEOUT))) begin
          w_state_next = ST_DONE;
        end
      end
      ST_RUN: begin
        if (r_num_words == '0) begin
          w_state_next = ST_DONE;
        end else if (w_valid && (w_word_inc == r_num_words)) begin
          w_state_next = ST_DONE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    if (io_bus.i_abort) begin
      w_state_next = ST_IDLE;
      w_accept     = 1'b0;
    end
  end

  // A zero-length run must not strobe, so the divider stays off for it.
  assign w_div_load = (r_state == ST_LOAD) && (w_state_next == ST_ACQ);
  assign w_div_en   = (w_state_next == ST_ACQ) ||
                      ((w_state_next == ST_RUN) && (r_num_words != '0));

  lfsr_seq_ctrl_rate_div #(
    .DIV_W (DIV_W)
  ) u_rate_div (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_div_load),
    .i_en    (w_div_en),
    .i_div   (r_div),
    .o_tick  (w_valid)
  );

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_seed       <= '0;
      r_num_words  <= '0;
      r_div        <= '0;
      r_word_cnt   <= '0;
      r_loss_cnt   <= '0;
      r_acq_cnt    <= '0;
      r_lock_prev  <= 1'b0;
      r_pass       <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_soft_reset <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_lock_prev  <= io_bus.i_lock;
      r_soft_reset <= (w_state_next == ST_LOAD);
      r_busy       <= st_is_busy(w_state_next);
      r_done       <= (w_state_next == ST_DONE) && (r_state != ST_DONE);

      if (w_accept) begin
        r_seed      <= io_bus.i_seed;
        r_num_words <= io_bus.i_num_words;
        r_div       <= io_bus.i_div;
        r_word_cnt  <= '0;
        r_loss_cnt  <= '0;
        r_acq_cnt   <= '0;
        r_pass      <= 1'b0;
      end else if (io_bus.i_abort) begin
        r_pass <= 1'b0;
      end else begin
        case (r_state)
          ST_ACQ: begin
            if (w_valid) begin
              r_acq_cnt <= w_acq_inc;
            end
            if (w_state_next == ST_DONE) begin
              r_pass <= 1'b0;
            end
          end
          ST_RUN: begin
            r_loss_cnt <= w_loss_next;
            if (w_valid) begin
              r_word_cnt <= w_word_inc;
            end
            if (w_state_next == ST_DONE) begin
              r_pass <= w_pass_run;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign io_bus.o_soft_reset = r_soft_reset;
  assign io_bus.o_seed       = r_seed;
  assign io_bus.o_valid      = w_valid;
  assign io_bus.o_busy       = r_busy;
  assign io_bus.o_done       = r_done;
  assign io_bus.o_pass       = r_pass;
  assign io_bus.o_word_cnt   = r_word_cnt;
  assign io_bus.o_loss_cnt   = r_loss_cnt;

endmodule
